// File: rtl/conv_tile_feeder.sv
// Stream-to-tile front end: buffers four raster rows and emits overlapping 4x4
// tiles at stride 2 alongside the frame's kernel word.
module conv_tile_feeder #(
  parameter int unsigned IMG_W = 8,
  parameter int unsigned IMG_H = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          kern_valid,
  input  logic [71:0]   kern_data,
  output logic          kern_ready,
  input  logic          pix_valid,
  input  logic [7:0]    pix_data,
  output logic          pix_ready,
  output logic          tile_valid,
  input  logic          tile_ready,
  output logic [127:0]  image,
  output logic [71:0]   kernel,
  output logic [7:0]    tile_row,
  output logic [7:0]    tile_col,
  output logic          tile_last
);

  localparam int unsigned XW = $clog2(IMG_W);
  localparam int unsigned YW = $clog2(IMG_H);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_FILL = 2'd1;
  localparam logic [1:0] S_EMIT = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [XW-1:0] ox_q, ox_d;
  logic [YW-1:0] oy_q, oy_d;
  logic [7:0]    buf_q [4][IMG_W];
  logic [7:0]    buf_d [4][IMG_W];

  logic          kern_ready_q, kern_ready_d;
  logic          pix_ready_q, pix_ready_d;
  logic          tile_valid_q, tile_valid_d;
  logic          tile_last_q, tile_last_d;
  logic [127:0]  image_q, image_d;
  logic [71:0]   kernel_q, kernel_d;
  logic [7:0]    tile_row_q, tile_row_d;
  logic [7:0]    tile_col_q, tile_col_d;

  // Next state, counters, line buffer and registered tile outputs
  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    ox_d         = ox_q;
    oy_d         = oy_q;
    buf_d        = buf_q;
    kernel_d     = kernel_q;
    image_d      = image_q;
    tile_row_d   = tile_row_q;
    tile_col_d   = tile_col_q;
    tile_last_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (kern_valid && kern_ready_q) begin
          kernel_d = kern_data;
          x_d      = '0;
          y_d      = '0;
          state_d  = S_FILL;
        end
      end
      S_FILL: begin
        if (pix_valid && pix_ready_q) begin
          buf_d[y_q[1:0]][x_q] = pix_data;
          if (x_q == XW'(IMG_W - 1)) begin
            x_d = '0;
            y_d = y_q + YW'(1);
            // Odd row >= 3 completes a four-row band
            if (y_q >= YW'(3) && y_q[0]) begin
              state_d = S_EMIT;
              oy_d    = y_q - YW'(3);
              ox_d    = '0;
            end
          end else begin
            x_d = x_q + XW'(1);
          end
        end
      end
      S_EMIT: begin
        if (tile_ready && tile_valid_q) begin
          if (ox_q != XW'(IMG_W - 4)) begin
            ox_d = ox_q + XW'(2);
          end else if (oy_q == YW'(IMG_H - 4)) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_FILL;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    kern_ready_d = (state_d == S_IDLE);
    pix_ready_d  = (state_d == S_FILL);
    tile_valid_d = (state_d == S_EMIT);

    // Tile is built from the post-write buffer so it is ready one cycle after the band completes
    if (state_d == S_EMIT) begin
      tile_row_d  = 8'(oy_d >> 1);
      tile_col_d  = 8'(ox_d >> 1);
      tile_last_d = (ox_d == XW'(IMG_W - 4)) && (oy_d == YW'(IMG_H - 4));
      for (int r = 0; r < 4; r++) begin
        for (int c = 0; c < 4; c++) begin
          image_d[(4*r+c)*8 +: 8] = buf_d[2'(oy_d[1:0] + 2'(r))][ox_d + XW'(c)];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      x_q          <= '0;
      y_q          <= '0;
      ox_q         <= '0;
      oy_q         <= '0;
      buf_q        <= '{default: '0};
      kern_ready_q <= 1'b1;
      pix_ready_q  <= 1'b0;
      tile_valid_q <= 1'b0;
      tile_last_q  <= 1'b0;
      image_q      <= '0;
      kernel_q     <= '0;
      tile_row_q   <= '0;
      tile_col_q   <= '0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      ox_q         <= ox_d;
      oy_q         <= oy_d;
      buf_q        <= buf_d;
      kern_ready_q <= kern_ready_d;
      pix_ready_q  <= pix_ready_d;
      tile_valid_q <= tile_valid_d;
      tile_last_q  <= tile_last_d;
      image_q      <= image_d;
      kernel_q     <= kernel_d;
      tile_row_q   <= tile_row_d;
      tile_col_q   <= tile_col_d;
    end
  end

  assign kern_ready = kern_ready_q;
  assign pix_ready  = pix_ready_q;
  assign tile_valid = tile_valid_q;
  assign tile_last  = tile_last_q;
  assign image      = image_q;
  assign kernel     = kernel_q;
  assign tile_row   = tile_row_q;
  assign tile_col   = tile_col_q;

endmodule

// File: tb/tb_conv_tile_feeder.sv
// Scoreboard bench for conv_tile_feeder: 8x8 frames with and without
// backpressure, mid-band reset, ignored inputs, plus a 4x4 minimum frame.
module tb_conv_tile_feeder;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic         kern_valid, kern_ready, pix_valid, pix_ready;
  logic         tile_valid, tile_ready, tile_last;
  logic [71:0]  kern_data, kernel;
  logic [7:0]   pix_data, tile_row, tile_col;
  logic [127:0] image;

  logic         m_kern_valid, m_kern_ready, m_pix_valid, m_pix_ready;
  logic         m_tile_valid, m_tile_ready, m_tile_last;
  logic [71:0]  m_kern_data, m_kernel;
  logic [7:0]   m_pix_data, m_tile_row, m_tile_col;
  logic [127:0] m_image;

  typedef struct packed {
    logic [127:0] image;
    logic [71:0]  kernel;
    logic [7:0]   row;
    logic [7:0]   col;
    logic         last;
  } tile_t;

  localparam logic [71:0] K1    = 72'h090807060504030201;
  localparam logic [71:0] K2    = 72'h0a0b0c0d0e0f101112;
  localparam logic [71:0] KBOGUS = 72'h112233445566778899;

  tile_t sb[$];
  int    n_checks = 0;
  int    n_pass   = 0;
  int    n_tiles  = 0;
  bit    mon_en   = 1'b0;
  int    tr_mode  = 0;

  conv_tile_feeder #(.IMG_W(8), .IMG_H(8)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .kern_valid(kern_valid), .kern_data(kern_data), .kern_ready(kern_ready),
    .pix_valid(pix_valid), .pix_data(pix_data), .pix_ready(pix_ready),
    .tile_valid(tile_valid), .tile_ready(tile_ready),
    .image(image), .kernel(kernel), .tile_row(tile_row), .tile_col(tile_col),
    .tile_last(tile_last)
  );

  conv_tile_feeder #(.IMG_W(4), .IMG_H(4)) u_min (
    .clk(clk), .rst_n(rst_n),
    .kern_valid(m_kern_valid), .kern_data(m_kern_data), .kern_ready(m_kern_ready),
    .pix_valid(m_pix_valid), .pix_data(m_pix_data), .pix_ready(m_pix_ready),
    .tile_valid(m_tile_valid), .tile_ready(m_tile_ready),
    .image(m_image), .kernel(m_kernel), .tile_row(m_tile_row), .tile_col(m_tile_col),
    .tile_last(m_tile_last)
  );

  // Expected 8x8 tile for pixel pattern p(y,x)=8y+x
  function automatic logic [127:0] exp_img(input int row, input int col);
    logic [127:0] v;
    v = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        v[(4*r+c)*8 +: 8] = 8'(8*(2*row + r) + 2*col + c);
    return v;
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic check_reset_main(input string name);
    chk(name, 256'({kern_ready, pix_ready, tile_valid, tile_last, tile_row, tile_col, kernel, image}),
        256'({4'b1000, 8'd0, 8'd0, 72'd0, 128'd0}));
  endtask

  // Downstream ready pattern: 0 = always ready, 1 = 0,0,1 repeating
  initial begin : ready_drv
    int bp_cnt;
    bp_cnt = 0;
    tile_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      bp_cnt++;
      tile_ready = (tr_mode == 1) ? (bp_cnt % 3 == 2) : 1'b1;
    end
  end

  // Monitor: compare every presented tile (including stalled cycles) with the queue head
  initial begin : monitor
    tile_t act;
    forever begin
      @(negedge clk);
      if (mon_en && rst_n && tile_valid) begin
        act.image  = image;
        act.kernel = kernel;
        act.row    = tile_row;
        act.col    = tile_col;
        act.last   = tile_last;
        chk("pix_ready during EMIT", 256'(pix_ready), 256'(0));
        if (sb.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected tile: got row %0d col %0d expected none", tile_row, tile_col);
        end else begin
          chk("tile", 256'(act), 256'(sb[0]));
          if (tile_ready) begin
            void'(sb.pop_front());
            n_tiles++;
          end
        end
      end
    end
  end

  task automatic send_kernel(input logic [71:0] k);
    int n;
    n = 0;
    @(posedge clk); #1;
    kern_data  = k;
    kern_valid = 1'b1;
    do begin @(negedge clk); n++; end while (!kern_ready && n < 200);
    if (!kern_ready) begin
      n_checks++;
      $display("FAIL kernel handshake: got kern_ready 0 expected 1 within 200 cycles");
      kern_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    kern_valid = 1'b0;
    chk("ready after kernel", 256'({kern_ready, pix_ready}), 256'(2'b01));
  endtask

  task automatic send_pixel(input logic [7:0] p);
    int n;
    n = 0;
    @(posedge clk); #1;
    pix_data  = p;
    pix_valid = 1'b1;
    do begin @(negedge clk); n++; end while (!pix_ready && n < 200);
    if (!pix_ready) begin
      n_checks++;
      $display("FAIL pixel handshake: got pix_ready 0 expected 1 within 200 cycles");
      pix_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    pix_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (!(sb.size() == 0 && kern_ready) && n < 2000);
    chk("frame drained", 256'({sb.size() == 0, kern_ready}), 256'(2'b11));
    chk("tile count", 256'(n_tiles), 256'(9));
    sb.delete();
  endtask

  task automatic run_frame(input logic [71:0] k, input bit bogus);
    tile_t t;
    n_tiles = 0;
    for (int row = 0; row < 3; row++) begin
      for (int col = 0; col < 3; col++) begin
        t.image  = exp_img(row, col);
        t.kernel = k;
        t.row    = 8'(row);
        t.col    = 8'(col);
        t.last   = (row == 2 && col == 2);
        sb.push_back(t);
      end
    end
    send_kernel(k);
    if (bogus) begin
      kern_data  = KBOGUS;
      kern_valid = 1'b1;
    end
    for (int i = 0; i < 64; i++) send_pixel(8'(i));
    kern_valid = 1'b0;
    wait_done();
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int n;
    rst_n = 1'b0;
    kern_valid = 1'b0; kern_data = '0; pix_valid = 1'b0; pix_data = '0;
    m_kern_valid = 1'b0; m_kern_data = '0; m_pix_valid = 1'b0; m_pix_data = '0;
    m_tile_ready = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_main("reset state");
    chk("min reset state", 256'({m_kern_ready, m_pix_ready, m_tile_valid, m_tile_last, m_image}),
        256'({4'b1000, 128'd0}));
    rst_n = 1'b1;

    // Minimum 4x4 frame
    @(posedge clk); #1;
    m_kern_data  = K2;
    m_kern_valid = 1'b1;
    @(negedge clk);
    chk("min kern_ready idle", 256'(m_kern_ready), 256'(1));
    @(posedge clk); #1;
    m_kern_valid = 1'b0;
    chk("min ready after kernel", 256'({m_kern_ready, m_pix_ready}), 256'(2'b01));
    for (int i = 0; i < 16; i++) begin
      m_pix_data  = 8'(i);
      m_pix_valid = 1'b1;
      n = 0;
      do begin @(negedge clk); n++; end while (!m_pix_ready && n < 50);
      if (!m_pix_ready) begin
        n_checks++;
        $display("FAIL min pixel handshake: got pix_ready 0 expected 1");
        break;
      end
      @(posedge clk); #1;
      m_pix_valid = 1'b0;
    end
    m_pix_valid = 1'b0;
    chk("min tile", 256'({m_tile_valid, m_tile_last, m_pix_ready, m_tile_row, m_tile_col, m_kernel, m_image}),
        256'({3'b110, 8'd0, 8'd0, K2, 128'h0f0e0d0c0b0a09080706050403020100}));
    @(posedge clk); #1;
    chk("min return to idle", 256'({m_kern_ready, m_tile_valid, m_pix_ready}), 256'(3'b100));

    // 8x8 frame, in-order tiles, no backpressure
    mon_en  = 1'b1;
    tr_mode = 0;
    run_frame(K1, 1'b0);

    // Pixels offered in IDLE are not accepted
    pix_data  = 8'hAA;
    pix_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("pix_ready in IDLE", 256'(pix_ready), 256'(0));
    end
    pix_valid = 1'b0;

    // Backpressure 0,0,1 with a competing kernel offered during FILL/EMIT
    tr_mode = 1;
    run_frame(K1, 1'b1);

    // Reset during the second tile of band 0
    mon_en  = 1'b0;
    tr_mode = 0;
    send_kernel(K1);
    for (int i = 0; i < 32; i++) send_pixel(8'(i));
    chk("band latency", 256'({tile_valid, pix_ready}), 256'(2'b10));
    @(negedge clk);
    chk("band0 tile0", 256'({tile_valid, tile_row, tile_col, image}), 256'({1'b1, 8'd0, 8'd0, exp_img(0, 0)}));
    @(negedge clk);
    chk("band0 tile1", 256'({tile_valid, tile_row, tile_col, image}), 256'({1'b1, 8'd0, 8'd1, exp_img(0, 1)}));
    rst_n = 1'b0;
    #1;
    check_reset_main("mid-band reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_main("after reset release");
    sb.delete();
    mon_en = 1'b1;
    run_frame(K1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
